fft_out_reorder: RTL



---
 rtl/fft_out_reorder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural order with ready/valid output
// Optional build macro FFT_REORDER_OVF_EN: drop samples aimed at an unread bank and raise sticky ovf.
module fft_out_reorder #(
  parameter int LOG_N = 6,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  input  logic             oready,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i,
  output logic             ovf
);

  localparam int N = 1 << LOG_N;
  // rcnt runs 1..N; reaching N means the sample in the output register is the last one
  localparam logic [LOG_N:0] RCNT_END = (LOG_N + 1)'(N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int k = 0; k < LOG_N; k++) begin
      r[k] = a[LOG_N-1-k];
    end
    return r;
  endfunction

  // Two banks stored back to back; the bank select is the address MSB.
  logic [WIDTH-1:0] mem_r_q [2*N];
  logic [WIDTH-1:0] mem_i_q [2*N];

  // Writer state
  logic [LOG_N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic             wr_en;
  logic [LOG_N:0]   wr_addr;

  // Reader state
  rd_state_t        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [LOG_N:0]   rcnt_q, rcnt_d;
  logic             oen_q, oen_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] oi_q, oi_d;
  logic             rd_load;
  logic [LOG_N:0]   rd_addr;
  logic [WIDTH-1:0] rd_data_r;
  logic [WIDTH-1:0] rd_data_i;

`ifdef FFT_REORDER_OVF_EN
  logic ovf_q, ovf_d;

  // A sample aimed at a bank still awaiting readout is dropped and flagged.
  always_comb begin
    wr_en = idata_en & ~full_q[wbank_q];
    ovf_d = ovf_q | (idata_en & full_q[wbank_q]);
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Writes always proceed; an unread bank gets overwritten if the reader falls behind.
  always_comb begin
    wr_en = idata_en;
  end

  assign ovf = 1'b0;
`endif

  assign wr_addr = {wbank_q, bitrev(wcnt_q)};

  // Writer: advance the sample counter and hand a completed bank to the reader.
  always_comb begin
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    full_set = 2'b00;
    if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (&wcnt_q) begin
        full_set[wbank_q] = 1'b1;
        wbank_d           = ~wbank_q;
      end
    end
  end

  // Bank ownership flags; a set from the writer beats a clear from the reader.
  always_comb begin
    full_d = (full_q & ~full_clr) | full_set;
  end

  // Reader FSM: pick the next natural-order address and decide when to load the output register.
  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    rcnt_d   = rcnt_q;
    oen_d    = oen_q;
    full_clr = 2'b00;
    rd_load  = 1'b0;
    rd_addr  = {rbank_q, {LOG_N{1'b0}}};
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_load = 1'b1;
          rd_addr = {rbank_q, {LOG_N{1'b0}}};
          oen_d   = 1'b1;
          rcnt_d  = (LOG_N + 1)'(1);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (oen_q && oready) begin
          if (rcnt_q < RCNT_END) begin
            rd_load = 1'b1;
            rd_addr = {rbank_q, rcnt_q[LOG_N-1:0]};
            rcnt_d  = rcnt_q + 1'b1;
          end else begin
            full_clr[rbank_q] = 1'b1;
            rbank_d           = ~rbank_q;
            if (full_q[~rbank_q]) begin
              // next frame already waiting: start it on this edge so there is no bubble
              rd_load = 1'b1;
              rd_addr = {~rbank_q, {LOG_N{1'b0}}};
              rcnt_d  = (LOG_N + 1)'(1);
            end else begin
              oen_d   = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_data_r = mem_r_q[rd_addr];
  assign rd_data_i = mem_i_q[rd_addr];

  // Output register only changes when the reader loads a new sample.
  always_comb begin
    or_d = or_q;
    oi_d = oi_q;
    if (rd_load) begin
      or_d = rd_data_r;
      oi_d = rd_data_i;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= 2'b00;
      state_q <= ST_IDLE;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
      oen_q   <= 1'b0;
      or_q    <= '0;
      oi_q    <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
      oen_q   <= oen_d;
      or_q    <= or_d;
      oi_q    <= oi_d;
    end
  end

  // Sample storage, written at the bit-reversed address; not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r_q[wr_addr] <= idata_r;
      mem_i_q[wr_addr] <= idata_i;
    end
  end

  assign odata_en = oen_q;
  assign odata_r  = or_q;
  assign odata_i  = oi_q;

endmodule
